// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and defaults for the clock burst scheduler
package clk_sched_pkg;

    localparam int CNT_W_DEF        = 8;
    localparam int BURST_W_DEF      = 16;
    localparam int DUT_HALF_RST_DEF = 2;
    localparam int ADC_HALF_RST_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/clk_half_div.sv
// rtl/clk_half_div.sv - half-period divider: counter, toggle register, rise/fall flags
module clk_half_div #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_half,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_clk,
    output logic             o_rise,
    output logic             o_fall
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_tc;

    assign w_tc   = (r_cnt == i_half - CNT_W'(1));
    assign o_clk  = r_clk;
    assign o_rise = !i_load && i_en && w_tc && !r_clk;
    assign o_fall = !i_load && i_en && w_tc && r_clk;

    // Without enable the counter parks at 0 and the clock level is frozen.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_clk <= 1'b0;
        end else if (i_en) begin
            if (w_tc) begin
                r_cnt <= '0;
                r_clk <= !r_clk;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/clk_burst_scheduler.sv
// rtl/clk_burst_scheduler.sv - glitch-free DUT/ADC clock sequencer with sample-counted bursts
// Optional ADC phase offset: define CLK_SCHED_ADC_PHASE_EN.
module clk_burst_scheduler
    import clk_sched_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int BURST_W      = BURST_W_DEF,
    parameter int DUT_HALF_RST = DUT_HALF_RST_DEF,
    parameter int ADC_HALF_RST = ADC_HALF_RST_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_dut_half,
    input  logic [CNT_W-1:0]   cfg_adc_half,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef CLK_SCHED_ADC_PHASE_EN
    input  logic [CNT_W-1:0]   cfg_adc_phase,
`endif
    input  logic               start,
    input  logic               stop,
    output logic               dut_clk,
    output logic               adc_clk,
    output logic               adc_sample_stb,
    output logic [BURST_W-1:0] sample_cnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_dut_half, r_adc_half, r_adc_phase;
    logic [BURST_W-1:0] r_burst, r_sample_cnt;
    logic               r_stb, r_done;
    logic               w_cfg_ready, w_load, w_dut_en, w_adc_en, w_burst_hit;
    logic [CNT_W-1:0]   w_adc_load_val, w_adc_phase_lim;
    logic               w_dut_clk, w_adc_clk, w_adc_rise;
    logic               w_dut_rise_unused, w_dut_fall_unused, w_adc_fall_unused;

    assign w_burst_hit     = (r_burst != '0) && (r_sample_cnt == r_burst);
    assign w_adc_phase_lim = (r_adc_phase > r_adc_half - CNT_W'(1)) ? r_adc_half - CNT_W'(1) : r_adc_phase;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && !stop)           w_state_nxt = ST_ALIGN;
            ST_ALIGN: w_state_nxt = stop ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (stop || w_burst_hit)      w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (!w_dut_clk && !w_adc_clk) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // A high clock in FLUSH keeps counting so it can only fall at terminal count.
    always_comb begin
        w_cfg_ready    = (r_state == ST_IDLE);
        w_load         = (r_state == ST_IDLE) || (r_state == ST_ALIGN);
        w_adc_load_val = (r_state == ST_ALIGN) ? w_adc_phase_lim : '0;
        w_dut_en       = (r_state == ST_RUN) || ((r_state == ST_FLUSH) && w_dut_clk);
        w_adc_en       = (r_state == ST_RUN) || ((r_state == ST_FLUSH) && w_adc_clk);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_half  <= CNT_W'(DUT_HALF_RST);
            r_adc_half  <= CNT_W'(ADC_HALF_RST);
            r_adc_phase <= '0;
            r_burst     <= '0;
        end else if (cfg_valid && w_cfg_ready) begin
            r_dut_half  <= (cfg_dut_half == '0) ? CNT_W'(1) : cfg_dut_half;
            r_adc_half  <= (cfg_adc_half == '0) ? CNT_W'(1) : cfg_adc_half;
`ifdef CLK_SCHED_ADC_PHASE_EN
            r_adc_phase <= cfg_adc_phase;
`else
            r_adc_phase <= '0;
`endif
            r_burst     <= cfg_burst;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_stb        <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_stb  <= (r_state == ST_RUN) && w_adc_rise;
            r_done <= (r_state == ST_FLUSH) && (w_state_nxt == ST_IDLE);
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_ALIGN))
                r_sample_cnt <= '0;
            else if ((r_state == ST_RUN) && w_adc_rise && (r_sample_cnt != '1))
                r_sample_cnt <= r_sample_cnt + BURST_W'(1);
        end
    end

    clk_half_div #(.CNT_W(CNT_W)) u_dut_div (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .i_half     (r_dut_half),
        .i_load     (w_load),
        .i_load_val ('0),
        .i_en       (w_dut_en),
        .o_clk      (w_dut_clk),
        .o_rise     (w_dut_rise_unused),
        .o_fall     (w_dut_fall_unused)
    );

    clk_half_div #(.CNT_W(CNT_W)) u_adc_div (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .i_half     (r_adc_half),
        .i_load     (w_load),
        .i_load_val (w_adc_load_val),
        .i_en       (w_adc_en),
        .o_clk      (w_adc_clk),
        .o_rise     (w_adc_rise),
        .o_fall     (w_adc_fall_unused)
    );

    assign cfg_ready      = w_cfg_ready;
    assign dut_clk        = w_dut_clk;
    assign adc_clk        = w_adc_clk;
    assign adc_sample_stb = r_stb;
    assign sample_cnt     = r_sample_cnt;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign state_dbg      = r_state;

endmodule
